// File: rtl/pattern_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
package pattern_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A pattern length is usable only if it is non-zero and fits the history register.
    function automatic logic len_legal(input logic [3:0] len, input logic [3:0] max_len);
        return (len != 4'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// History shift register, fill counter and masked comparator of the detector.
module pattern_match_core
    import pattern_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
    input  logic               overlap,
    output logic               match
);

    localparam logic [3:0] MAX_FILL = 4'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_r;
    logic [MAX_LEN-1:0] hist_next_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [3:0]         fill_r;
    logic [3:0]         fill_next_s;

    // The match decision looks at the history as it will be after the incoming bit.
    always_comb begin
        hist_next_s = {hist_r[MAX_LEN-2:0], x};
        fill_next_s = (fill_r == MAX_FILL) ? fill_r : (fill_r + 4'd1);
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (4'(i) < len);
        end
        match = shift_en && (fill_next_s >= len) &&
                (((hist_next_s ^ pattern) & mask_s) == {MAX_LEN{1'b0}});
    end

    // History and fill update; non-overlap mode restarts the fill after a hit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= 4'd0;
        end else if (clear) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= 4'd0;
        end else if (shift_en) begin
            hist_r <= hist_next_s;
            fill_r <= (match && !overlap) ? 4'd0 : fill_next_s;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Run-controlled serial pattern detector: config latch, IDLE/ARMED/DONE FSM and match counter.
module pattern_detect_ctrl
    import pattern_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               x,
    input  logic               x_valid,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [3:0]       MAX_LEN4 = 4'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    state_t             state_r;
    state_t             state_next_s;
    logic [MAX_LEN-1:0] pat_r;
    logic [3:0]         len_r;
    logic               ovl_r;
    logic [CNT_W-1:0]   tgt_r;

    logic               cfg_ok_s;
    logic               cfg_bad_s;
    logic               arm_s;
    logic               step_s;
    logic               core_match_s;
    logic               hit_s;
    logic               reach_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               z_next_s;
    logic               done_next_s;
    logic               busy_next_s;

    // Abort suppresses the shift so a same-edge match never counts.
    always_comb begin
        cfg_ok_s  = cfg_we && (state_r == ST_IDLE) && len_legal(cfg_len, MAX_LEN4);
        cfg_bad_s = cfg_we && !cfg_ok_s;
        arm_s     = (state_r == ST_IDLE) && start;
        step_s    = (state_r == ST_ARMED) && x_valid && !abort;
        hit_s     = step_s && core_match_s;
        cnt_inc_s = (&match_cnt) ? match_cnt : (match_cnt + CNT_ONE);
        reach_s   = hit_s && (tgt_r != {CNT_W{1'b0}}) && (cnt_inc_s == tgt_r);
    end

    pattern_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (arm_s),
        .shift_en (step_s),
        .x        (x),
        .pattern  (pat_r),
        .len      (len_r),
        .overlap  (ovl_r),
        .match    (core_match_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ARMED;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (reach_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ARMED;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode, taken from the next state so the registered flags align with it.
    always_comb begin
        z_next_s    = hit_s;
        done_next_s = (state_r == ST_ARMED) && (state_next_s == ST_DONE);
        busy_next_s = (state_next_s == ST_ARMED);
    end

    // Configuration latch, writable only while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= {MAX_LEN{1'b0}};
            len_r <= 4'd1;
            ovl_r <= 1'b0;
            tgt_r <= {CNT_W{1'b0}};
        end else if (cfg_ok_s) begin
            pat_r <= cfg_pattern;
            len_r <= cfg_len;
            ovl_r <= cfg_overlap;
            tgt_r <= cfg_target;
        end
    end

    // Match counter: cleared on start, held after the run ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= {CNT_W{1'b0}};
        end else if (arm_s) begin
            match_cnt <= {CNT_W{1'b0}};
        end else if (hit_s) begin
            match_cnt <= cnt_inc_s;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z       <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            z       <= z_next_s;
            done    <= done_next_s;
            busy    <= busy_next_s;
            cfg_err <= cfg_bad_s;
        end
    end

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Directed and random checks of pattern_detect_ctrl against a queue-based reference model.
module tb_pattern_detect_ctrl;

    localparam int ML = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = 8'd0;
    logic [3:0] cfg_len = 4'd1;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = 8'd0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       z, busy, done, cfg_err;
    logic [7:0] match_cnt;
    logic       z2, busy2, done2, cfg_err2;
    logic [1:0] match_cnt2;

    int errors = 0;
    int checks = 0;
    int zcount = 0;
    int z2count = 0;
    bit chk2 = 1'b0;

    // reference model state
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_tgt;
    bit         m_armed, m_indone;
    bit         q[$];
    int         m_cnt, m_cnt2;
    bit         e_z, e_done, e_err;

    always #5 clk = ~clk;

    pattern_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
        .x(x), .x_valid(x_valid), .z(z), .match_cnt(match_cnt), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    pattern_detect_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]), .start(start), .abort(abort),
        .x(x), .x_valid(x_valid), .z(z2), .match_cnt(match_cnt2), .busy(busy2), .done(done2),
        .cfg_err(cfg_err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'd0; m_len = 1; m_ovl = 1'b0; m_tgt = 0;
        m_armed = 1'b0; m_indone = 1'b0; q.delete();
        m_cnt = 0; m_cnt2 = 0;
        e_z = 1'b0; e_done = 1'b0; e_err = 1'b0;
    endtask

    function automatic bit tail_match();
        if (q.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // one clock edge of the intended behaviour, from the inputs held across that edge
    task automatic model_edge();
        e_z = 1'b0; e_done = 1'b0; e_err = 1'b0;
        if (cfg_we) begin
            if (!m_armed && !m_indone && cfg_len >= 4'd1 && cfg_len <= 4'd8) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
            end else begin
                e_err = 1'b1;
            end
        end
        if (m_indone) begin
            m_indone = 1'b0;
        end else if (!m_armed) begin
            if (start) begin
                m_armed = 1'b1; q.delete(); m_cnt = 0; m_cnt2 = 0;
            end
        end else if (abort) begin
            m_armed = 1'b0;
        end else if (x_valid) begin
            q.push_back(x);
            if (q.size() > ML) void'(q.pop_front());
            if (tail_match()) begin
                e_z = 1'b1;
                m_cnt  = (m_cnt  == 255) ? 255 : m_cnt + 1;
                m_cnt2 = (m_cnt2 == 3)   ? 3   : m_cnt2 + 1;
                if (!m_ovl) q.delete();
                if (m_tgt != 0 && m_cnt == m_tgt) begin
                    e_done = 1'b1; m_armed = 1'b0; m_indone = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #1;
        if (z)  zcount++;
        if (z2) z2count++;
        check("z", z, e_z);
        check("done", done, e_done);
        check("busy", busy, m_armed);
        check("cfg_err", cfg_err, e_err);
        check("match_cnt", match_cnt, m_cnt);
        if (chk2) begin
            check("z2", z2, e_z);
            check("done2", done2, e_done);
            check("busy2", busy2, m_armed);
            check("cfg_err2", cfg_err2, e_err);
            check("match_cnt2", match_cnt2, m_cnt2);
        end
    endtask

    task automatic drive(input bit we, input bit st, input bit ab, input bit xv, input bit xb);
        cfg_we = we; start = st; abort = ab; x_valid = xv; x = xb;
        tick();
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input bit o, input logic [7:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
    endtask

    task automatic send(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b0, 1'b0, 1'b1, bits[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_z"}, z, 32'd0);
        check({tag, "_done"}, done, 32'd0);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_cfg_err"}, cfg_err, 32'd0);
        check({tag, "_cnt"}, match_cnt, 32'd0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b1;

        // long pattern, target 2, config written on the same edge as start
        set_cfg(8'b0111_1001, 4'd7, 1'b0, 8'd2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        zcount = 0;
        send(8'b0111_1001, 7);
        check("t2_first_cnt", match_cnt, 32'd1);
        send(8'b0111_1001, 7);
        check("t2_done", done, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_zcount", zcount, 32'd2);
        check("t2_cnt", match_cnt, 32'd2);
        check("t2_busy_after", busy, 32'd0);

        // 101 over 10101: overlapping then non-overlapping
        set_cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        zcount = 0;
        send(8'b0001_0101, 5);
        check("ovl_zcount", zcount, 32'd2);
        check("ovl_busy", busy, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_cfg(8'b0000_0101, 4'd3, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        zcount = 0;
        send(8'b0001_0101, 5);
        check("novl_zcount", zcount, 32'd1);
        check("novl_busy", busy, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // abort on the completing bit wins over the match
        set_cfg(8'b0111_1001, 4'd7, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'b0011_1100, 6);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_z", z, 32'd0);
        check("abort_cnt", match_cnt, 32'd0);
        check("abort_busy", busy, 32'd0);

        // illegal lengths and write while armed are rejected
        set_cfg(8'hFF, 4'd0, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("len0_err", cfg_err, 32'd1);
        set_cfg(8'hFF, 4'd9, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("len9_err", cfg_err, 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        zcount = 0;
        send(8'b0111_1001, 7);
        check("cfg_kept_zcount", zcount, 32'd1);
        set_cfg(8'b0000_0001, 4'd1, 1'b1, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("armed_we_err", cfg_err, 32'd1);

        // reset in the middle of a run
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send(8'b0001_1110, 5);
        #2 rst = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        set_cfg(8'b0111_1001, 4'd7, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        zcount = 0;
        send(8'b0111_1001, 7);
        check("rerun_zcount", zcount, 32'd1);
        check("rerun_cnt", match_cnt, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // 2-bit counter saturation
        chk2 = 1'b1;
        set_cfg(8'b0000_0001, 4'd1, 1'b0, 8'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        z2count = 0;
        send(8'b0001_1111, 5);
        check("sat_cnt2", match_cnt2, 32'd3);
        check("sat_z2count", z2count, 32'd5);
        check("sat_cnt8", match_cnt, 32'd5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk2 = 1'b0;

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            bit we, st, ab;
            r  = int'($urandom_range(0, 99));
            we = 1'b0; st = 1'b0; ab = 1'b0;
            if (r < 4) begin
                we = 1'b1;
                set_cfg(8'($urandom), 4'($urandom_range(0, 9)), 1'($urandom), 8'($urandom_range(0, 3)));
                if ($urandom_range(0, 2) != 0) cfg_len = 4'($urandom_range(1, 3));
            end
            if (r >= 4 && r < 10) st = 1'b1;
            if (r == 10) ab = 1'b1;
            if ($urandom_range(0, 9) == 0) st = 1'b1;
            drive(we, st, ab, ($urandom_range(0, 9) < 7), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
